perf_report_sequencer: RTL

Sequences the transmission of a snapshot of the cache performance counters over the byte-wide UART transmitter. On a trigger it captures all counter values in one cycle and emits a framed byte stream: sync byte, each counter MSB-first, then an XOR checksum. Each byte is handed to the UART with a start pulse, and the block waits for the UART's busy handshake between bytes. It sits between the event counter bank and `uart_tx` in the FPGA top level, on the memory clock.

---
 rtl/perf_report_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/perf_report_sequencer.sv
// Snapshots the counter bank and streams it to uart_tx as a framed byte
// sequence: SYNC, counters MSB-first, XOR checksum of the payload bytes.
module perf_report_sequencer #(
    parameter int         NUM_CNT = 9,
    parameter int         CNT_W   = 32,
    parameter logic [7:0] SYNC    = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     trigger,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_flat,
    input  logic                     tx_busy,
    output logic [7:0]               tx_din,
    output logic                     tx_start,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam int BPC   = CNT_W / 8;
    localparam int NB    = NUM_CNT * BPC;
    localparam int TOT   = NUM_CNT * CNT_W;
    localparam int IDX_W = $clog2(NB + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_HI,
        S_WAIT_LO,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [TOT-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       chk_q, chk_d;
    logic [1:0]       guard_q, guard_d;
    logic [7:0]       tx_din_q, tx_din_d;
    logic             tx_start_q, tx_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic             advance;
    logic [TOT-1:0]   ordered;

    // Shadow holds payload in transmit order so the frame is a plain left shift.
    always_comb begin
        ordered = '0;
        for (int c = 0; c < NUM_CNT; c++) begin
            for (int b = 0; b < BPC; b++) begin
                ordered[TOT-8-8*(c*BPC+b) +: 8] =
                    cnt_flat[c*CNT_W + CNT_W-8-8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        idx_d      = idx_q;
        chk_d      = chk_q;
        guard_d    = guard_q;
        tx_din_d   = tx_din_q;
        tx_start_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q;
        advance    = 1'b0;

        if (trigger && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    shadow_d  = ordered;
                    idx_d     = '0;
                    chk_d     = '0;
                    busy_d    = 1'b1;
                    overrun_d = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_start_d = 1'b1;
                guard_d    = '0;
                state_d    = S_WAIT_HI;
                if (idx_q == '0) begin
                    tx_din_d = SYNC;
                end else if (idx_q == LAST_IDX) begin
                    tx_din_d = chk_q;
                end else begin
                    tx_din_d = shadow_q[TOT-1 -: 8];
                    chk_d    = chk_q ^ shadow_q[TOT-1 -: 8];
                    shadow_d = shadow_q << 8;
                end
            end
            S_WAIT_HI: begin
                // A UART that never raises busy is treated as already done.
                if (tx_busy) begin
                    state_d = S_WAIT_LO;
                end else if (guard_q == 2'd3) begin
                    advance = 1'b1;
                end else begin
                    guard_d = guard_q + 2'd1;
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    advance = 1'b1;
                end
            end
            S_FIN: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d = S_FIN;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_LOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            shadow_q   <= '0;
            idx_q      <= '0;
            chk_q      <= '0;
            guard_q    <= '0;
            tx_din_q   <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            idx_q      <= idx_d;
            chk_q      <= chk_d;
            guard_q    <= guard_d;
            tx_din_q   <= tx_din_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign tx_din   = tx_din_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule
